// File: rtl/serial_subtractor.sv
// Bit-serial N-bit subtractor (D = X - Y), one bit per clock, LSB first,
// with borrow-out and signed-overflow flags behind a soc/eoc handshake.
module serial_subtractor #(
   parameter int N = 8
) (
   input  logic         clock,
   input  logic         reset_,
   input  logic         soc,
   input  logic [N-1:0] X,
   input  logic [N-1:0] Y,
   output logic         eoc,
   output logic [N-1:0] D,
   output logic         b_out,
   output logic         ow
);

   localparam int CW = $clog2(N);
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      CALC     = 2'd1,
      WAIT_LOW = 2'd2
   } state_t;

   state_t         state_q, state_d;
   logic [N-1:0]   x_q, x_d;
   logic [N-1:0]   y_q, y_d;
   logic [N-1:0]   diff_q, diff_d;
   logic           borrow_q, borrow_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           b_out_q, b_out_d;
   logic           ow_q, ow_d;

   logic           x_bit, y_bit, diff_bit, borrow_nxt, last_step;

   // Operand registers shift right, so the bit being processed is always at index 0.
   assign x_bit      = x_q[0];
   assign y_bit      = y_q[0];
   assign diff_bit   = x_bit ^ y_bit ^ borrow_q;
   assign borrow_nxt = (~x_bit & y_bit) | (~(x_bit ^ y_bit) & borrow_q);
   assign last_step  = (cnt_q == LAST);

   always_ff @(posedge clock or negedge reset_) begin
      if (!reset_) begin
         state_q  <= IDLE;
         x_q      <= '0;
         y_q      <= '0;
         diff_q   <= '0;
         borrow_q <= 1'b0;
         cnt_q    <= '0;
         b_out_q  <= 1'b0;
         ow_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         x_q      <= x_d;
         y_q      <= y_d;
         diff_q   <= diff_d;
         borrow_q <= borrow_d;
         cnt_q    <= cnt_d;
         b_out_q  <= b_out_d;
         ow_q     <= ow_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:     if (soc) state_d = CALC;
         CALC:     if (last_step) state_d = WAIT_LOW;
         // A held soc must drop before another operation can start.
         WAIT_LOW: if (!soc) state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   always_comb begin
      x_d      = x_q;
      y_d      = y_q;
      diff_d   = diff_q;
      borrow_d = borrow_q;
      cnt_d    = cnt_q;
      b_out_d  = b_out_q;
      ow_d     = ow_q;
      case (state_q)
         IDLE: begin
            if (soc) begin
               x_d      = X;
               y_d      = Y;
               diff_d   = '0;
               borrow_d = 1'b0;
               cnt_d    = '0;
            end
         end
         CALC: begin
            x_d      = {1'b0, x_q[N-1:1]};
            y_d      = {1'b0, y_q[N-1:1]};
            diff_d   = {diff_bit, diff_q[N-1:1]};
            borrow_d = borrow_nxt;
            cnt_d    = cnt_q + CW'(1);
            if (last_step) begin
               cnt_d   = '0;
               b_out_d = borrow_nxt;
               // Overflow: operand signs differ and the result sign differs from X.
               ow_d    = (x_bit ^ y_bit) & (diff_bit ^ x_bit);
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      eoc   = (state_q != CALC);
      D     = diff_q;
      b_out = b_out_q;
      ow    = ow_q;
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: directed vector table, handshake/reset sequences,
// and random operations checked against an arithmetic reference model.
module tb_serial_subtractor;

   localparam int N = 8;

   logic         clock = 1'b0;
   logic         reset_;
   logic         soc;
   logic [N-1:0] X, Y;
   logic         eoc;
   logic [N-1:0] D;
   logic         b_out;
   logic         ow;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [N-1:0] x;
      logic [N-1:0] y;
      logic [N-1:0] exp_d;
      logic         exp_b;
      logic         exp_ow;
   } vec_t;

   vec_t vecs[8];

   serial_subtractor #(.N(N)) dut (
      .clock (clock),
      .reset_(reset_),
      .soc   (soc),
      .X     (X),
      .Y     (Y),
      .eoc   (eoc),
      .D     (D),
      .b_out (b_out),
      .ow    (ow)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference model straight from the arithmetic definition.
   task automatic model(input logic [N-1:0] x, input logic [N-1:0] y,
                        output logic [N-1:0] d, output logic b, output logic o);
      int sx, sy, sd;
      d  = N'(x - y);
      b  = (int'(x) < int'(y));
      sx = int'($signed(x));
      sy = int'($signed(y));
      sd = sx - sy;
      o  = (sd > (2**(N-1) - 1)) || (sd < -(2**(N-1)));
   endtask

   // One full operation; optionally scrambles X/Y after chg_at CALC edges.
   task automatic run_op(input logic [N-1:0] x, input logic [N-1:0] y,
                         input int chg_at, input logic [N-1:0] nx, input logic [N-1:0] ny,
                         input logic [N-1:0] exp_d, input logic exp_b, input logic exp_ow,
                         input string name);
      int lat;
      @(posedge clock); #1;
      X = x; Y = y; soc = 1'b1;
      @(posedge clock); #1;
      soc = 1'b0;
      check({name, "_start_eoc"}, 32'(eoc), 32'd0);
      check({name, "_start_d"}, 32'(D), 32'd0);
      lat = 0;
      do begin
         @(posedge clock); #1;
         lat++;
         if (lat == chg_at) begin X = nx; Y = ny; end
      end while (!eoc && lat < N + 4);
      check({name, "_latency"}, 32'(lat), 32'(N));
      check({name, "_d"}, 32'(D), 32'(exp_d));
      check({name, "_b"}, 32'(b_out), 32'(exp_b));
      check({name, "_ow"}, 32'(ow), 32'(exp_ow));
      $display("op %s: X=%02h Y=%02h -> D=%02h b_out=%0d ow=%0d lat=%0d",
               name, x, y, D, b_out, ow, lat);
   endtask

   initial begin
      logic [N-1:0] rx, ry, ed, nx, ny;
      logic         eb, eo;
      int           low, chg;

      vecs[0] = '{8'h08, 8'h00, 8'h08, 1'b0, 1'b0};
      vecs[1] = '{8'h00, 8'h01, 8'hFF, 1'b1, 1'b0};
      vecs[2] = '{8'h80, 8'h80, 8'h00, 1'b0, 1'b0};
      vecs[3] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
      vecs[4] = '{8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1};
      vecs[5] = '{8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0};
      vecs[6] = '{8'h00, 8'h80, 8'h80, 1'b1, 1'b1};
      vecs[7] = '{8'h01, 8'h02, 8'hFF, 1'b1, 1'b0};

      reset_ = 1'b0; soc = 1'b0; X = '0; Y = '0;
      #12;
      check("rst_eoc", 32'(eoc), 32'd1);
      check("rst_d", 32'(D), 32'd0);
      check("rst_b", 32'(b_out), 32'd0);
      check("rst_ow", 32'(ow), 32'd0);
      @(posedge clock); #1;
      reset_ = 1'b1;

      for (int i = 0; i < 8; i++)
         run_op(vecs[i].x, vecs[i].y, 0, '0, '0,
                vecs[i].exp_d, vecs[i].exp_b, vecs[i].exp_ow, $sformatf("vec%0d", i));

      // Held soc: exactly one operation, eoc low for N sampled cycles only.
      @(posedge clock); #1;
      X = 8'h10; Y = 8'h01; soc = 1'b1;
      low = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clock); #1;
         if (!eoc) low++;
      end
      check("hold_low_cycles", 32'(low), 32'(N));
      check("hold_eoc_end", 32'(eoc), 32'd1);
      check("hold_d", 32'(D), 32'h0F);
      $display("op hold: X=10 Y=01 soc held 20 cycles -> D=%02h low_cycles=%0d", D, low);
      soc = 1'b0;
      @(posedge clock); #1;
      check("hold_release_eoc", 32'(eoc), 32'd1);
      run_op(8'h20, 8'h01, 0, '0, '0, 8'h1F, 1'b0, 1'b0, "after_hold");

      // Operand changes during CALC must be ignored.
      run_op(8'h05, 8'h03, 3, 8'hAA, 8'h55, 8'h02, 1'b0, 1'b0, "stable");

      // Leave flags set, then abort a later op with an asynchronous reset.
      run_op(8'h7F, 8'hFF, 0, '0, '0, 8'h80, 1'b1, 1'b1, "pre_reset");
      @(posedge clock); #1;
      X = 8'hF0; Y = 8'h0F; soc = 1'b1;
      @(posedge clock); #1;
      soc = 1'b0;
      repeat (3) @(posedge clock);
      #3 reset_ = 1'b0;
      #1;
      check("midrst_eoc", 32'(eoc), 32'd1);
      check("midrst_d", 32'(D), 32'd0);
      check("midrst_b", 32'(b_out), 32'd0);
      check("midrst_ow", 32'(ow), 32'd0);
      $display("op midrst: reset during step 4 -> eoc=%0d D=%02h b_out=%0d ow=%0d", eoc, D, b_out, ow);
      @(posedge clock); #1;
      reset_ = 1'b1;
      run_op(8'h03, 8'h05, 0, '0, '0, 8'hFE, 1'b1, 1'b0, "post_reset");

      for (int i = 0; i < 40; i++) begin
         rx  = N'($urandom);
         ry  = N'($urandom);
         nx  = N'($urandom);
         ny  = N'($urandom);
         chg = int'($urandom_range(0, N - 1));
         model(rx, ry, ed, eb, eo);
         run_op(rx, ry, chg, nx, ny, ed, eb, eo, $sformatf("rnd%0d", i));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial N-bit subtractor computing D = X - Y, with borrow-out and two's-complement overflow flags.
- Sequential counterpart to the team's combinational adder (same X/Y operands, flag semantics mirrored for subtraction).
- Driven by a soc/eoc start/done handshake so a controller can issue operations and wait for results.
- Processes one bit per clock, LSB first, trading latency for area.

Parameters:
- N, 8, operand and result width in bits (N >= 2).

Ports:
- clock  input  1  system clock, all state updates on rising edge
- reset_  input  1  asynchronous, active-low reset
- soc  input  1  start of conversion, request from controller
- X  input  N  minuend, sampled only on accepted start
- Y  input  N  subtrahend, sampled only on accepted start
- eoc  output  1  end of conversion; 1 = idle or result valid, 0 = busy
- D  output  N  difference X - Y mod 2^N
- b_out  output  1  borrow out; 1 iff X < Y as unsigned
- ow  output  1  signed overflow; 1 iff X - Y is outside [-2^(N-1), 2^(N-1)-1] as two's complement

Behaviour:
- Reset and clock: one clock, reset is asynchronous and active-low; ports named clock and reset_.
- While reset_=0: state=IDLE, eoc=1, D=0, b_out=0, ow=0, internal borrow=0, bit counter=0.
- Reset mid-operation aborts immediately; no partial result is retained.
- FSM states: IDLE, CALC, WAIT_LOW.
- IDLE:
  - eoc=1.
  - On an edge with soc=1: latch X and Y into internal shift registers, clear borrow and counter, clear D, go to CALC.
  - eoc=0 from that edge.
  - Otherwise hold state and outputs (the previous result stays visible).
- CALC:
  - eoc=0.
  - Each edge processes bit i = counter, using b as the current borrow:
    - d_i = x_i ^ y_i ^ b
    - b_next = (~x_i & y_i) | (~(x_i ^ y_i) & b)
  - d_i is shifted into D from the MSB side, so after N steps D holds the full result in natural bit order.
  - Counter increments per step.
  - On the edge that processes bit N-1:
    - b_out = final borrow.
    - ow = (x_{N-1} != y_{N-1}) & (d_{N-1} != x_{N-1}).
    - eoc=1, go to WAIT_LOW.
  - Changes on X, Y and soc during CALC are ignored.
- Timing:
  - Start accepted at edge k; eoc falls at k and rises at edge k+N.
  - D, b_out and ow are valid and stable from edge k+N.
- WAIT_LOW:
  - eoc=1; outputs held.
  - Go to IDLE on the first edge with soc=0.
  - While soc stays 1, no new operation starts (no retrigger from a held soc).
  - Minimum spacing between accepted starts is N+2 cycles.
- Outputs D, b_out and ow change only on:
  - reset,
  - the start edge (D cleared),
  - CALC steps (D shifting), or
  - the final edge (flags set).
- Flags are undefined-free: they are always 0 or 1, never X after reset.

Test Plan:
1. Basic: reset_ low then high; X=0x08, Y=0x00, soc pulse -> eoc low for 8 cycles, then D=0x08, b_out=0, ow=0, eoc=1.
2. Borrow: X=0x00, Y=0x01 -> D=0xFF, b_out=1, ow=0; X=0x80, Y=0x80 -> D=0x00, b_out=0, ow=0.
3. Overflow: X=0x80, Y=0x01 -> D=0x7F, b_out=0, ow=1; X=0x7F, Y=0xFF -> D=0x80, b_out=1, ow=1.
4. Handshake: hold soc=1 for 20 cycles with X=0x10, Y=0x01 -> exactly one operation, D=0x0F; eoc stays 1 after edge k+8; a new start is accepted only after soc=0 is seen for one cycle.
5. Operand stability: change X/Y to 0xAA/0x55 on cycle 3 of CALC for start X=0x05, Y=0x03 -> D=0x02, b_out=0, ow=0.
6. Reset mid-op: start X=0xF0, Y=0x0F, pull reset_ low asynchronously mid-cycle during step 4 -> eoc=1, D=0x00, b_out=0, ow=0 immediately; after release the next start X=0x03, Y=0x05 gives D=0xFE, b_out=1, ow=0.
